regfile_writeback: RTL and testbench

Write-back unit driving the single write port of the 32×32 register file. It merges two result sources into one registered write per cycle:
- the in-order pipeline result from MEM/WB, which is never stalled;
- results from the multi-cycle multiply/divide unit, which use a valid/ready handshake.

It aligns and extends load data, suppresses writes to register 0, and buffers long-latency results in a small queue.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wb_queue.sv | 68 ++++++
 rtl/regfile_writeback.sv | 77 +++++++
 tb/tb_regfile_writeback.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: load size encodings, default widths and the write-back queue entry type
package regfile_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0] data;
    logic                  valid;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: compacting FIFO of DEPTH md results; push/pop/kill-by-dest in, head/full/empty out
module wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_dest,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill,
  input  logic [ADDR_W-1:0] kill_dest,
  output logic [ADDR_W-1:0] head_dest,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] dest_nxt [DEPTH];
  logic [DATA_W-1:0] data_nxt [DEPTH];
  logic [CW-1:0] count, count_nxt;
  assign head_dest = dest_q[0];
  assign head_data = data_q[0];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_comb begin
    int k;
    logic keep;
    dest_nxt = dest_q;
    data_nxt = data_q;
    k = 0;
    keep = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      keep = CW'(i) < count && !(pop && i == 0) && !(kill && dest_q[i] == kill_dest);
      for (int j = 0; j < DEPTH; j++) begin
        if (keep && k == j) begin
          dest_nxt[j] = dest_q[i];
          data_nxt[j] = data_q[i];
        end
      end
      k = k + (keep ? 1 : 0);
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (push && k == j) begin
        dest_nxt[j] = push_dest;
        data_nxt[j] = push_data;
      end
    end
    count_nxt = CW'(k + ((push && k < DEPTH) ? 1 : 0));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      dest_q <= dest_nxt;
      data_q <= data_nxt;
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges MEM/WB results (pipe_*) and queued md results (md_*) into one registered regfile write (address_d/data_dval/write_enable)
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int Q_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_dest,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              pipe_is_load,
  input  logic [1:0]        pipe_size,
  input  logic              pipe_signed,
  input  logic [1:0]        pipe_offset,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_dest,
  input  logic [DATA_W-1:0] md_data,
  output logic [ADDR_W-1:0] address_d,
  output logic [DATA_W-1:0] data_dval,
  output logic              write_enable,
  output logic              md_pending
);
  logic [7:0] byte_lane;
  logic [15:0] half_lane;
  logic [DATA_W-1:0] pipe_res;
  logic pipe_wr, push, pop, q_full, q_empty;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;
  assign byte_lane = pipe_data[{pipe_offset, 3'b000} +: 8];
  assign half_lane = pipe_data[{pipe_offset[1], 4'b0000} +: 16];
  always_comb begin
    pipe_res = pipe_data;
    if (pipe_is_load)
      pipe_res = pipe_size == SZ_BYTE ? {{(DATA_W-8){pipe_signed & byte_lane[7]}}, byte_lane} :
                 pipe_size == SZ_HALF ? {{(DATA_W-16){pipe_signed & half_lane[15]}}, half_lane} :
                 pipe_data;
  end
  assign pipe_wr = pipe_valid && pipe_dest != '0;
  assign pop = !pipe_wr && !q_empty;
  assign push = md_valid && md_ready && md_dest != '0;
  assign md_ready = !q_full;
  assign md_pending = !q_empty;
  wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(Q_DEPTH)) u_queue (
    .clock(clock),
    .reset_n(reset_n),
    .push(push),
    .push_dest(md_dest),
    .push_data(md_data),
    .pop(pop),
    .kill(pipe_wr),
    .kill_dest(pipe_dest),
    .head_dest(head_dest),
    .head_data(head_data),
    .full(q_full),
    .empty(q_empty)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_enable <= 1'b0;
      address_d <= '0;
      data_dval <= '0;
    end else begin
      write_enable <= pipe_wr || pop;
      if (pipe_wr) begin
        address_d <= pipe_dest;
        data_dval <= pipe_res;
      end else if (pop) begin
        address_d <= head_dest;
        data_dval <= head_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: table-driven load checks, directed corner sequences and random traffic against a queue model
module tb_regfile_writeback;
  import regfile_pkg::*;
  localparam int QD = 2;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic pipe_valid = 1'b0, pipe_is_load = 1'b0, pipe_signed = 1'b0, md_valid = 1'b0;
  logic [4:0] pipe_dest = '0, md_dest = '0;
  logic [31:0] pipe_data = '0, md_data = '0;
  logic [1:0] pipe_size = '0, pipe_offset = '0;
  logic md_ready, write_enable, md_pending;
  logic [4:0] address_d;
  logic [31:0] data_dval;
  int compared = 0, mismatched = 0;
  wb_entry_t mq[$];
  logic [4:0] m_addr = '0;
  logic [31:0] m_data = '0;
  typedef struct {
    logic ld;
    logic [1:0] sz;
    logic sg;
    logic [1:0] off;
    logic [31:0] exp;
  } vec_t;
  vec_t tab[12];
  regfile_writeback #(.DATA_W(32), .ADDR_W(5), .Q_DEPTH(QD)) dut (
    .clock(clock), .reset_n(reset_n),
    .pipe_valid(pipe_valid), .pipe_dest(pipe_dest), .pipe_data(pipe_data),
    .pipe_is_load(pipe_is_load), .pipe_size(pipe_size), .pipe_signed(pipe_signed),
    .pipe_offset(pipe_offset), .md_valid(md_valid), .md_ready(md_ready),
    .md_dest(md_dest), .md_data(md_data), .address_d(address_d),
    .data_dval(data_dval), .write_enable(write_enable), .md_pending(md_pending)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_load(input logic ld, input logic [1:0] sz, input logic sg,
                                           input logic [1:0] off, input logic [31:0] d);
    logic [31:0] v;
    if (!ld || sz == SZ_WORD || sz == 2'b11) return d;
    if (sz == SZ_BYTE) begin
      v = (d >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else begin
      v = (d >> (16 * (off / 2))) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction
  task automatic step();
    bit rdy, exp_we;
    wb_entry_t e;
    rdy = mq.size() < QD;
    chk("md_ready", 32'(md_ready), 32'(rdy));
    @(posedge clock);
    exp_we = 1'b0;
    if (pipe_valid && pipe_dest != 0) begin
      exp_we = 1'b1;
      m_addr = pipe_dest;
      m_data = ref_load(pipe_is_load, pipe_size, pipe_signed, pipe_offset, pipe_data);
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].dest == pipe_dest) mq.delete(i);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_we = 1'b1;
      m_addr = e.dest;
      m_data = e.data;
    end
    if (md_valid && rdy && md_dest != 0) mq.push_back('{dest: md_dest, data: md_data, valid: 1'b1});
    #1;
    chk("write_enable", 32'(write_enable), 32'(exp_we));
    chk("address_d", 32'(address_d), 32'(m_addr));
    chk("data_dval", data_dval, m_data);
    chk("md_pending", 32'(md_pending), 32'(mq.size() != 0));
  endtask
  task automatic set_pipe(input logic v, input logic [4:0] d, input logic [31:0] x);
    pipe_valid = v;
    pipe_dest = d;
    pipe_data = x;
    pipe_is_load = 1'b0;
  endtask
  task automatic set_md(input logic v, input logic [4:0] d, input logic [31:0] x);
    md_valid = v;
    md_dest = d;
    md_data = x;
  endtask
  initial begin
    tab[0]  = '{1, SZ_BYTE, 1, 2'd3, 32'hFFFFFF80};
    tab[1]  = '{1, SZ_BYTE, 0, 2'd1, 32'h0000007F};
    tab[2]  = '{1, SZ_HALF, 1, 2'd2, 32'hFFFF80FF};
    tab[3]  = '{1, SZ_HALF, 1, 2'd3, 32'hFFFF80FF};
    tab[4]  = '{1, SZ_BYTE, 1, 2'd1, 32'h0000007F};
    tab[5]  = '{1, SZ_BYTE, 1, 2'd2, 32'hFFFFFFFF};
    tab[6]  = '{1, SZ_BYTE, 0, 2'd3, 32'h00000080};
    tab[7]  = '{1, SZ_HALF, 0, 2'd2, 32'h000080FF};
    tab[8]  = '{1, SZ_HALF, 1, 2'd0, 32'h00007F01};
    tab[9]  = '{1, SZ_WORD, 1, 2'd1, 32'h80FF7F01};
    tab[10] = '{1, 2'b11,   1, 2'd2, 32'h80FF7F01};
    tab[11] = '{0, SZ_BYTE, 1, 2'd3, 32'h80FF7F01};
    #7;
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_addr", 32'(address_d), 0);
    chk("rst_data", data_dval, 0);
    chk("rst_pending", 32'(md_pending), 0);
    #3 reset_n = 1'b1;
    #6;
    set_pipe(1, 5'd5, 32'h1234ABCD);
    step();
    chk("first_we", 32'(write_enable), 1);
    chk("first_addr", 32'(address_d), 5);
    chk("first_data", data_dval, 32'h1234ABCD);
    set_pipe(0, 0, 0);
    step();
    chk("single_pulse", 32'(write_enable), 0);
    for (int i = 0; i < 12; i++) begin
      set_pipe(1, 5'(i + 1), 32'h80FF7F01);
      pipe_is_load = tab[i].ld;
      pipe_size = tab[i].sz;
      pipe_signed = tab[i].sg;
      pipe_offset = tab[i].off;
      step();
      chk($sformatf("load_vec%0d", i), data_dval, tab[i].exp);
    end
    set_pipe(1, 5'd1, 32'h1);
    set_md(1, 5'd7, 32'h55);
    step();
    set_pipe(1, 5'd0, 32'h99);
    set_md(0, 0, 0);
    step();
    chk("dest0_drain_we", 32'(write_enable), 1);
    chk("dest0_drain_addr", 32'(address_d), 7);
    chk("dest0_drain_data", data_dval, 32'h55);
    set_pipe(0, 0, 0);
    set_md(1, 5'd0, 32'hDEAD);
    step();
    set_md(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("md0_no_write", 32'(write_enable), 0);
      chk("md0_pending", 32'(md_pending), 0);
    end
    set_pipe(1, 5'd10, 32'hA0);
    set_md(1, 5'd3, 32'h33);
    step();
    set_pipe(1, 5'd11, 32'hA1);
    set_md(1, 5'd4, 32'h44);
    step();
    set_pipe(1, 5'd12, 32'hA2);
    set_md(1, 5'd5, 32'h66);
    chk("full_not_ready", 32'(md_ready), 0);
    step();
    set_pipe(0, 0, 0);
    set_md(0, 0, 0);
    step();
    chk("drain1_addr", 32'(address_d), 3);
    chk("drain1_we", 32'(write_enable), 1);
    step();
    chk("drain2_addr", 32'(address_d), 4);
    chk("drain2_data", data_dval, 32'h44);
    chk("drained_pending", 32'(md_pending), 0);
    chk("drained_ready", 32'(md_ready), 1);
    step();
    set_pipe(1, 5'd1, 32'h2);
    set_md(1, 5'd9, 32'hAA);
    step();
    set_pipe(1, 5'd9, 32'hBB);
    set_md(0, 0, 0);
    step();
    chk("kill_data", data_dval, 32'hBB);
    chk("kill_pending", 32'(md_pending), 0);
    set_pipe(0, 0, 0);
    step();
    chk("kill_no_write", 32'(write_enable), 0);
    set_pipe(1, 5'd1, 32'h3);
    set_md(1, 5'd20, 32'h111);
    step();
    set_pipe(1, 5'd2, 32'h4);
    set_md(1, 5'd21, 32'h222);
    step();
    set_pipe(0, 0, 0);
    set_md(0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(write_enable), 0);
    chk("async_rst_addr", 32'(address_d), 0);
    chk("async_rst_data", data_dval, 0);
    chk("async_rst_pending", 32'(md_pending), 0);
    mq.delete();
    m_addr = '0;
    m_data = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_write", 32'(write_enable), 0);
    end
    for (int i = 0; i < 400; i++) begin
      set_pipe($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      pipe_is_load = $urandom_range(0, 1) == 1;
      pipe_size = 2'($urandom_range(0, 3));
      pipe_signed = $urandom_range(0, 1) == 1;
      pipe_offset = 2'($urandom_range(0, 3));
      set_md($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
